// File: rtl/mac_rx_fcs_ctrl_if.sv
// Receive stream beats from the RX MAC and the per-frame FCS verdict returned to it.
interface mac_rx_fcs_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic              valid_i;
    logic              start_i;
    logic              last_i;
    logic [1:0]        len_i;
    logic              cancel_i;
    logic [DATA_W-1:0] data_i;
    logic              fcs_valid_o;
    logic              fcs_ok_o;
    logic              abort_o;
    logic              busy_o;

    modport master (
        output valid_i, start_i, last_i, len_i, cancel_i, data_i,
        input  fcs_valid_o, fcs_ok_o, abort_o, busy_o
    );

    modport slave (
        input  valid_i, start_i, last_i, len_i, cancel_i, data_i,
        output fcs_valid_o, fcs_ok_o, abort_o, busy_o
    );
endinterface

// File: rtl/mac_rx_fcs_ctrl.sv
// Sequences the crc32_rx engine for the MAC RX path, folds 1-3 byte tails locally and flags FCS pass/fail.
// Optional good/bad frame counters are built when MAC_RX_FCS_STATS_EN is defined.
module mac_rx_fcs_ctrl #(
    parameter int unsigned        DATA_W  = 32,
    parameter logic [DATA_W-1:0]  RESIDUE = 32'hC704DD7B
`ifdef MAC_RX_FCS_STATS_EN
    ,
    parameter int unsigned        CNT_W   = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    mac_rx_fcs_ctrl_if.slave      rx,
    output logic                  crc_start_o,
    output logic                  crc_valid_o,
    output logic [DATA_W-1:0]     crc_data_o,
    input  logic [DATA_W-1:0]     crc_i
`ifdef MAC_RX_FCS_STATS_EN
    ,
    output logic [CNT_W-1:0]      good_cnt_o,
    output logic [CNT_W-1:0]      bad_cnt_o
`endif
);

    localparam logic [DATA_W-1:0] POLY = DATA_W'(32'h04C11DB7);

    typedef enum logic [2:0] {IDLE, BODY, FULL_CHK, TAIL, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] tail_data;
    logic [1:0]        tail_cnt;
    logic              tail_first;

    logic              in_frame;
    logic              kill;
    logic              new_frame;
    logic              word_acc;
    logic [DATA_W-1:0] fold_res;

    // One byte through the engine's serial step: MSB first, no reflection, no inversion.
    function automatic logic [DATA_W-1:0] fold_byte(input logic [DATA_W-1:0] r_in,
                                                    input logic [7:0]        b);
        logic [DATA_W-1:0] r;
        r = r_in;
        for (int i = 7; i >= 0; i--) begin
            if (r[DATA_W-1] ^ b[i]) r = {r[DATA_W-2:0], 1'b0} ^ POLY;
            else                    r = {r[DATA_W-2:0], 1'b0};
        end
        return r;
    endfunction

    // A cancel in-frame suppresses everything, including a start in the same beat.
    always_comb begin
        in_frame    = (state == BODY) || (state == FULL_CHK) || (state == TAIL);
        kill        = in_frame && rx.cancel_i;
        new_frame   = rx.valid_i && rx.start_i && !kill;
        word_acc    = new_frame || ((state == BODY) && rx.valid_i && !kill);
        crc_start_o = new_frame;
        crc_valid_o = word_acc && (!rx.last_i || (rx.len_i == 2'd0));
        crc_data_o  = rx.data_i;
        fold_res    = fold_byte(tail_first ? crc_i : rem, tail_data[DATA_W-1 -: 8]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rem            <= '0;
            tail_data      <= '0;
            tail_cnt       <= 2'd0;
            tail_first     <= 1'b0;
            rx.fcs_valid_o <= 1'b0;
            rx.fcs_ok_o    <= 1'b0;
            rx.abort_o     <= 1'b0;
            rx.busy_o      <= 1'b0;
        end else begin
            rx.fcs_valid_o <= 1'b0;
            rx.fcs_ok_o    <= 1'b0;
            rx.abort_o     <= 1'b0;
            if (kill) begin
                state      <= IDLE;
                rx.abort_o <= 1'b1;
                rx.busy_o  <= 1'b0;
            end else if (new_frame) begin
                // A start while a frame is open drops that frame.
                rx.abort_o <= in_frame;
                rx.busy_o  <= 1'b1;
                if (rx.last_i) begin
                    state          <= DONE;
                    rx.fcs_valid_o <= 1'b1;
                end else begin
                    state <= BODY;
                end
            end else begin
                case (state)
                    BODY: begin
                        if (rx.valid_i && rx.last_i) begin
                            if (rx.len_i == 2'd0) begin
                                state <= FULL_CHK;
                            end else begin
                                state      <= TAIL;
                                tail_data  <= rx.data_i;
                                tail_cnt   <= rx.len_i;
                                tail_first <= 1'b1;
                            end
                        end
                    end
                    FULL_CHK: begin
                        state          <= DONE;
                        rx.fcs_valid_o <= 1'b1;
                        rx.fcs_ok_o    <= (crc_i == RESIDUE);
                    end
                    TAIL: begin
                        rem        <= fold_res;
                        tail_data  <= {tail_data[DATA_W-9:0], 8'h00};
                        tail_cnt   <= tail_cnt - 2'd1;
                        tail_first <= 1'b0;
                        if (tail_cnt == 2'd1) begin
                            state          <= DONE;
                            rx.fcs_valid_o <= 1'b1;
                            rx.fcs_ok_o    <= (fold_res == RESIDUE);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        rx.busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MAC_RX_FCS_STATS_EN
    // Saturating verdict counters; aborted frames never produce a verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            good_cnt_o <= '0;
            bad_cnt_o  <= '0;
        end else if (rx.fcs_valid_o) begin
            if (rx.fcs_ok_o && !(&good_cnt_o)) good_cnt_o <= good_cnt_o + CNT_W'(1);
            if (!rx.fcs_ok_o && !(&bad_cnt_o)) bad_cnt_o <= bad_cnt_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mac_rx_fcs_ctrl.sv
// Scoreboard bench for mac_rx_fcs_ctrl with a behavioural crc32_rx engine model.
module tb_mac_rx_fcs_ctrl;

    logic        clk;
    logic        reset;
    logic        crc_start;
    logic        crc_valid;
    logic [31:0] crc_data;
    logic [31:0] eng;
`ifdef MAC_RX_FCS_STATS_EN
    logic [1:0]  good_cnt;
    logic [1:0]  bad_cnt;
`endif

    mac_rx_fcs_ctrl_if #(.DATA_W(32)) rx();

    mac_rx_fcs_ctrl #(
        .DATA_W (32)
`ifdef MAC_RX_FCS_STATS_EN
        ,
        .CNT_W  (2)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .crc_start_o (crc_start),
        .crc_valid_o (crc_valid),
        .crc_data_o  (crc_data),
        .crc_i       (eng)
`ifdef MAC_RX_FCS_STATS_EN
        ,
        .good_cnt_o  (good_cnt),
        .bad_cnt_o   (bad_cnt)
`endif
    );

    typedef struct {
        bit is_abort;
        bit ok;
        int when;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_start = 0;
    int   n_words = 0;
    int   good_exp = 0;
    int   bad_exp  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fold8(input logic [31:0] r_in, input logic [7:0] b);
        logic [31:0] r;
        r = r_in;
        for (int i = 7; i >= 0; i--) begin
            if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [31:0] step32(input logic [31:0] r_in, input logic [31:0] w);
        logic [31:0] r;
        r = fold8(r_in, w[31:24]);
        r = fold8(r, w[23:16]);
        r = fold8(r, w[15:8]);
        r = fold8(r, w[7:0]);
        return r;
    endfunction

    // crc32_rx engine: seed all-ones on start, remainder registered one cycle after the word.
    always @(posedge clk) begin
        if (reset)          eng <= 32'h0;
        else if (crc_valid) eng <= step32(crc_start ? 32'hFFFF_FFFF : eng, crc_data);
        else if (crc_start) eng <= 32'hFFFF_FFFF;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (crc_start) n_start++;
            if (crc_valid) n_words++;
            if (rx.fcs_valid_o || rx.abort_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: valid=%0b abort=%0b ok=%0b at cycle %0d, none required",
                             rx.fcs_valid_o, rx.abort_o, rx.fcs_ok_o, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rx.abort_o !== e.is_abort || rx.fcs_valid_o !== !e.is_abort ||
                        (!e.is_abort && rx.fcs_ok_o !== e.ok) || cyc != e.when) begin
                        errors++;
                        $display("FAIL event: got valid=%0b abort=%0b ok=%0b cycle=%0d, required abort=%0b ok=%0b cycle=%0d",
                                 rx.fcs_valid_o, rx.abort_o, rx.fcs_ok_o, cyc, e.is_abort, e.ok, e.when);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx.valid_i  = 1'b0;
        rx.start_i  = 1'b0;
        rx.last_i   = 1'b0;
        rx.len_i    = 2'd0;
        rx.cancel_i = 1'b0;
        rx.data_i   = 32'h0;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input bit is_abort, input bit ok, input int when);
        exp_q.push_back('{is_abort, ok, when});
        if (!is_abort) begin
            if (ok) good_exp++;
            else    bad_exp++;
        end
    endtask

    // Sends a frame of nbytes including a correct FCS; optional bit flip, cancel and mid-frame gap.
    task automatic send_frame(input int nbytes, input int flip_beat, input int cancel_beat,
                              input bit want_result, input bit exp_ok, input bit gap);
        logic [7:0]  q[$];
        logic [31:0] c;
        logic [31:0] w;
        int          nbeats;
        int          s0;
        int          w0;
        int          lat;
        int          exp_words;
        bit          cancelled;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < nbytes - 4; i++) begin
            q.push_back(8'(i * 7 + nbytes));
            c = fold8(c, q[i]);
        end
        c = ~c;
        q.push_back(c[31:24]);
        q.push_back(c[23:16]);
        q.push_back(c[15:8]);
        q.push_back(c[7:0]);
        nbeats    = (nbytes + 3) / 4;
        s0        = n_start;
        w0        = n_words;
        cancelled = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < 4; l++)
                w[31 - 8 * l -: 8] = (4 * b + l < nbytes) ? q[4 * b + l] : 8'hA5;
            if (b == flip_beat) w[0] = ~w[0];
            rx.valid_i  = 1'b1;
            rx.start_i  = (b == 0);
            rx.last_i   = (b == nbeats - 1);
            rx.len_i    = (b == nbeats - 1) ? 2'(nbytes % 4) : 2'd3;
            rx.cancel_i = (b == cancel_beat);
            rx.data_i   = w;
            if (b == cancel_beat) begin
                push_exp(1'b1, 1'b0, cyc + 1);
                tick();
                cancelled = 1'b1;
                break;
            end
            if (b == nbeats - 1 && want_result) begin
                lat = (nbeats == 1) ? 1 : ((nbytes % 4 == 0) ? 2 : (nbytes % 4) + 1);
                push_exp(1'b0, exp_ok, cyc + lat);
            end
            tick();
            if (gap && b == 3) begin
                rx.valid_i = 1'b0;
                rx.start_i = 1'b1;
                rx.last_i  = 1'b1;
                rx.data_i  = 32'hDEAD_BEEF;
                tick();
                tick();
            end
        end
        idle_inputs();
        if (cancelled)              exp_words = cancel_beat;
        else if (nbytes % 4 == 0)   exp_words = nbeats;
        else                        exp_words = nbeats - 1;
        check($sformatf("engine_words_%0dB", nbytes), n_words - w0, exp_words);
        check($sformatf("engine_starts_%0dB", nbytes), n_start - s0, 1);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (3) tick();
        reset = 1'b0;
        check("reset_outputs", int'({rx.fcs_valid_o, rx.fcs_ok_o, rx.abort_o, rx.busy_o}), 0);
        repeat (2) tick();

        send_frame(64, -1, -1, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        send_frame(65, -1, -1, 1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        send_frame(66, -1, -1, 1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        send_frame(67, -1, -1, 1'b1, 1'b1, 1'b0);
        repeat (6) tick();
        send_frame(64, 5, -1, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        send_frame(64, -1, -1, 1'b1, 1'b1, 1'b1);
        repeat (4) tick();

        send_frame(64, -1, 7, 1'b0, 1'b0, 1'b0);
        check("busy_after_cancel", int'(rx.busy_o), 0);
        repeat (2) tick();
        send_frame(64, -1, -1, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();

        // Frame B starts in the middle of frame A's tail fold.
        send_frame(67, -1, -1, 1'b0, 1'b0, 1'b0);
        tick();
        push_exp(1'b1, 1'b0, cyc + 1);
        send_frame(64, -1, -1, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();

        send_frame(4, -1, -1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();

        // Next frame starts in the result cycle of the previous one.
        send_frame(68, -1, -1, 1'b1, 1'b1, 1'b0);
        tick();
        send_frame(66, -1, -1, 1'b1, 1'b1, 1'b0);
        repeat (5) tick();

        rx.valid_i = 1'b1;
        rx.start_i = 1'b1;
        rx.data_i  = 32'h1234_5678;
        tick();
        rx.start_i = 1'b0;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        check("busy_after_reset", int'(rx.busy_o), 0);
        reset = 1'b0;
        tick();
        send_frame(65, -1, -1, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("pending_results", exp_q.size(), 0);
        repeat (3) tick();
        check("busy_at_end", int'(rx.busy_o), 0);
`ifdef MAC_RX_FCS_STATS_EN
        check("good_cnt", int'(good_cnt), (good_exp > 3) ? 3 : good_exp);
        check("bad_cnt", int'(bad_cnt), (bad_exp > 3) ? 3 : bad_exp);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
